// File: rtl/ipd_pkg.sv
// Shared definitions for the inter-packet delay gate: FSM encoding and mode selector values.
package ipd_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPass = 2'd1,
        StWait = 2'd2
    } ipd_state_e;

    localparam logic [1:0] DelayModeReg   = 2'd0;
    localparam logic [1:0] DelayModeTuser = 2'd1;
    localparam logic [1:0] DelayModeMax   = 2'd2;  // 2'd3 behaves the same

    localparam logic GapEndToStart   = 1'b0;
    localparam logic GapStartToStart = 1'b1;

endpackage

// File: rtl/ipd_gap_counter.sv
// Loadable down-counter that saturates at zero; a load with dec set counts the load cycle.
module ipd_gap_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             dec,
    output logic [Width-1:0] count,
    output logic             zero
);

    localparam logic [Width-1:0] One = {{(Width-1){1'b0}}, 1'b1};

    logic [Width-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= (dec && load_val != '0) ? load_val - One : load_val;
        end else if (dec && count_q != '0) begin
            count_q <= count_q - One;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/inter_packet_delay_mc.sv
// AXI-Stream pass-through that closes its gate for a programmable gap between packets,
// optionally only after every burst_len packets.
module inter_packet_delay_mc
    import ipd_pkg::*;
#(
    parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_DELAY_WIDTH      = 32,
    parameter int unsigned C_TUSER_DELAY_LSB  = 32
) (
    input  logic                            axi_aclk,
    input  logic                            axi_areset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    input  logic                            sw_rst,
    input  logic                            ipd_en,
    input  logic [1:0]                      delay_mode,
    input  logic                            gap_mode,
    input  logic [C_DELAY_WIDTH-1:0]        delay_reg_val,
    input  logic [7:0]                      burst_len,
    output logic [31:0]                     pkt_count,
    output logic                            gap_active
);

    localparam logic [C_DELAY_WIDTH-1:0] DelayOne = {{(C_DELAY_WIDTH-1){1'b0}}, 1'b1};

    ipd_state_e               state_q;
    logic [C_DELAY_WIDTH-1:0] delay_q, sel_delay, pkt_delay, tuser_delay, cnt_load_val, count;
    logic                     gap_mode_q, pkt_gap_mode;
    logic [7:0]               burst_len_q, burst_cnt_q, burst_lim;
    logic [31:0]              pkt_count_q;
    logic                     mid_frame_q;
    logic                     open, xfer, start, pkt_end, burst_done, gap_needed;
    logic                     cnt_load, cnt_dec, cnt_zero, cnt_last;

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tstrb  = s_axis_tstrb;
    assign m_axis_tuser  = s_axis_tuser;
    assign m_axis_tlast  = s_axis_tlast;

    assign open          = (state_q != StWait);
    assign m_axis_tvalid = s_axis_tvalid & open;
    assign s_axis_tready = m_axis_tready & open;
    assign xfer          = s_axis_tvalid & m_axis_tready & open;

    // A beat only opens a packet if the bus itself was between packets.
    assign start   = ipd_en & xfer & ~mid_frame_q & (state_q == StIdle);
    assign pkt_end = ipd_en & xfer & s_axis_tlast & (start | (state_q == StPass));

    assign tuser_delay = s_axis_tuser[C_TUSER_DELAY_LSB +: C_DELAY_WIDTH];
    assign cnt_last    = cnt_zero | (count == DelayOne);
    assign gap_active  = (state_q == StWait);
    assign pkt_count   = pkt_count_q;

    always_comb begin
        case (delay_mode)
            DelayModeReg:   sel_delay = delay_reg_val;
            DelayModeTuser: sel_delay = tuser_delay;
            default:        sel_delay = (tuser_delay > delay_reg_val) ? tuser_delay : delay_reg_val;
        endcase
        pkt_delay    = start ? sel_delay : delay_q;
        pkt_gap_mode = start ? gap_mode : gap_mode_q;
        burst_lim    = start ? burst_len : burst_len_q;
        if (burst_lim == 8'd0) burst_lim = 8'd1;
        burst_done   = (burst_cnt_q + 8'd1) >= burst_lim;

        // In start-to-start mode the gap is what the counter holds after this cycle's decrement.
        if (pkt_gap_mode == GapEndToStart) gap_needed = (pkt_delay != '0);
        else if (start)                    gap_needed = (sel_delay > DelayOne);
        else                               gap_needed = ~cnt_last;

        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b1;
        if (sw_rst || !ipd_en) begin
            cnt_load = 1'b1;
        end else if (pkt_end && burst_done && pkt_gap_mode == GapEndToStart) begin
            cnt_load     = 1'b1;
            cnt_load_val = pkt_delay;
            cnt_dec      = 1'b0;
        end else if (start && gap_mode == GapStartToStart) begin
            cnt_load     = 1'b1;
            cnt_load_val = sel_delay;
        end
    end

    ipd_gap_counter #(
        .Width(C_DELAY_WIDTH)
    ) u_gap_counter (
        .clk      (axi_aclk),
        .rst      (axi_areset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (count),
        .zero     (cnt_zero)
    );

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_q     <= StIdle;
            delay_q     <= '0;
            gap_mode_q  <= GapEndToStart;
            burst_len_q <= 8'd1;
            burst_cnt_q <= 8'd0;
        end else if (sw_rst) begin
            state_q     <= StIdle;
            delay_q     <= '0;
            gap_mode_q  <= GapEndToStart;
            burst_len_q <= 8'd1;
            burst_cnt_q <= 8'd0;
        end else if (!ipd_en) begin
            state_q     <= StIdle;
            burst_cnt_q <= 8'd0;
        end else begin
            if (start) begin
                delay_q     <= sel_delay;
                gap_mode_q  <= gap_mode;
                burst_len_q <= burst_len;
            end
            unique case (state_q)
                StIdle, StPass: begin
                    if (pkt_end) begin
                        if (burst_done) begin
                            burst_cnt_q <= 8'd0;
                            state_q     <= gap_needed ? StWait : StIdle;
                        end else begin
                            burst_cnt_q <= burst_cnt_q + 8'd1;
                            state_q     <= StIdle;
                        end
                    end else if (start) begin
                        state_q <= StPass;
                    end
                end
                StWait: if (cnt_last) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            pkt_count_q <= 32'd0;
        end else if (sw_rst) begin
            pkt_count_q <= 32'd0;
        end else if (xfer && s_axis_tlast && pkt_count_q != '1) begin
            pkt_count_q <= pkt_count_q + 32'd1;
        end
    end

    // Bus framing is tracked across resets so a packet cut by reset is not taken for a new one.
    always_ff @(posedge axi_aclk) begin
        if (xfer) mid_frame_q <= ~s_axis_tlast;
    end

endmodule

// File: tb/tb_inter_packet_delay_mc.sv
// Directed bench for inter_packet_delay_mc: table of gap scenarios plus reset/enable sequences.
module tb_inter_packet_delay_mc;

    localparam int DW  = 256;
    localparam int UW  = 128;
    localparam int LW  = 32;
    localparam int LSB = 32;

    logic            axi_aclk = 1'b0;
    logic            axi_areset;
    logic [DW-1:0]   s_axis_tdata, m_axis_tdata;
    logic [DW/8-1:0] s_axis_tstrb, m_axis_tstrb;
    logic [UW-1:0]   s_axis_tuser, m_axis_tuser;
    logic            s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic            m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic            sw_rst, ipd_en, gap_mode, gap_active;
    logic [1:0]      delay_mode;
    logic [LW-1:0]   delay_reg_val;
    logic [7:0]      burst_len;
    logic [31:0]     pkt_count;

    int   checks = 0;
    int   errors = 0;
    logic pt_bad;

    always #5 axi_aclk = ~axi_aclk;

    inter_packet_delay_mc dut (
        .axi_aclk      (axi_aclk),
        .axi_areset    (axi_areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .sw_rst        (sw_rst),
        .ipd_en        (ipd_en),
        .delay_mode    (delay_mode),
        .gap_mode      (gap_mode),
        .delay_reg_val (delay_reg_val),
        .burst_len     (burst_len),
        .pkt_count     (pkt_count),
        .gap_active    (gap_active)
    );

    typedef struct packed {
        logic            en;
        logic [1:0]      dmode;
        logic            gmode;
        logic [31:0]     dreg;
        logic [31:0]     tdly;
        logic [7:0]      blen;
        logic [7:0]      beats;
        logic [7:0]      npkts;
        logic [4:0][7:0] exp_stall;  // stall cycles seen before each packet's first beat
    } vec_t;

    function automatic vec_t mkv(input int en, input int dm, input int gm, input int dreg,
                                 input int tdly, input int blen, input int beats, input int npkts,
                                 input int s0, input int s1, input int s2, input int s3,
                                 input int s4);
        vec_t v;
        v.en        = 1'(en);
        v.dmode     = 2'(dm);
        v.gmode     = 1'(gm);
        v.dreg      = 32'(dreg);
        v.tdly      = 32'(tdly);
        v.blen      = 8'(blen);
        v.beats     = 8'(beats);
        v.npkts     = 8'(npkts);
        v.exp_stall = {8'(s4), 8'(s3), 8'(s2), 8'(s1), 8'(s0)};
        return v;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic pulse_sw_rst();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        sw_rst        = 1'b1;
        tick();
        sw_rst        = 1'b0;
    endtask

    // Streams one packet with tvalid held high; returns cycles the beat was held off.
    task automatic send_pkt(input int nbeats, input logic [LW-1:0] tdly, input bit eop,
                            output int stalls);
        int beat;
        int guard;
        beat   = 0;
        guard  = 0;
        stalls = 0;
        s_axis_tuser            = '0;
        s_axis_tuser[LSB +: LW] = tdly;
        s_axis_tvalid           = 1'b1;
        while (beat < nbeats && guard < 400) begin
            for (int k = 0; k < DW / 32; k++) s_axis_tdata[k*32 +: 32] = $urandom;
            s_axis_tstrb = $urandom;
            s_axis_tlast = eop && (beat == nbeats - 1);
            #1;
            if (m_axis_tdata !== s_axis_tdata || m_axis_tstrb !== s_axis_tstrb ||
                m_axis_tuser !== s_axis_tuser || m_axis_tlast !== s_axis_tlast ||
                s_axis_tready !== m_axis_tvalid)
                pt_bad = 1'b1;
            if (m_axis_tvalid) beat++;
            else stalls++;
            tick();
            guard++;
        end
        if (beat < nbeats) begin
            checks++;
            errors++;
            $display("FAIL send_pkt timeout: got %0d beats, want %0d", beat, nbeats);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [14];
        int   st;

        axi_areset    = 1'b1;
        sw_rst        = 1'b0;
        ipd_en        = 1'b0;
        delay_mode    = 2'd0;
        gap_mode      = 1'b0;
        delay_reg_val = '0;
        burst_len     = 8'd1;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b1;
        pt_bad        = 1'b0;

        repeat (2) @(posedge axi_aclk);
        #1;
        check("reset gap_active", gap_active, 0);
        check("reset pkt_count", pkt_count, 0);
        check("reset m_tvalid follows s_tvalid", m_axis_tvalid, 1);
        m_axis_tready = 1'b0;
        #1;
        check("reset s_tready follows m_tready", s_axis_tready, 0);
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b0;
        axi_areset    = 1'b0;
        tick();

        //               en dm gm dreg tdly bl bt np  stalls per packet
        vecs[0]  = mkv(1, 0, 0, 10,  0,   1, 4, 2,  0, 10, 0, 0, 0);
        vecs[1]  = mkv(1, 1, 0, 20,  5,   1, 4, 2,  0, 5,  0, 0, 0);
        vecs[2]  = mkv(1, 2, 0, 20,  5,   1, 4, 2,  0, 20, 0, 0, 0);
        vecs[3]  = mkv(1, 3, 0, 20,  30,  1, 4, 2,  0, 30, 0, 0, 0);
        vecs[4]  = mkv(1, 0, 1, 8,   0,   1, 6, 2,  0, 2,  0, 0, 0);
        vecs[5]  = mkv(1, 0, 1, 3,   0,   1, 6, 2,  0, 0,  0, 0, 0);
        vecs[6]  = mkv(1, 0, 1, 6,   0,   1, 6, 2,  0, 0,  0, 0, 0);
        vecs[7]  = mkv(1, 0, 1, 7,   0,   1, 6, 2,  0, 1,  0, 0, 0);
        vecs[8]  = mkv(1, 0, 0, 4,   0,   3, 1, 5,  0, 0,  0, 4, 0);
        vecs[9]  = mkv(0, 0, 0, 100, 0,   1, 4, 3,  0, 0,  0, 0, 0);
        vecs[10] = mkv(1, 0, 0, 2,   0,   0, 1, 3,  0, 2,  2, 0, 0);
        vecs[11] = mkv(1, 0, 1, 4,   0,   1, 1, 3,  0, 3,  3, 0, 0);
        vecs[12] = mkv(1, 0, 0, 0,   0,   1, 4, 2,  0, 0,  0, 0, 0);
        vecs[13] = mkv(1, 0, 0, 1,   0,   1, 2, 2,  0, 1,  0, 0, 0);

        foreach (vecs[i]) begin
            ipd_en        = vecs[i].en;
            delay_mode    = vecs[i].dmode;
            gap_mode      = vecs[i].gmode;
            delay_reg_val = vecs[i].dreg;
            burst_len     = vecs[i].blen;
            pulse_sw_rst();
            pt_bad = 1'b0;
            for (int p = 0; p < int'(vecs[i].npkts); p++) begin
                send_pkt(int'(vecs[i].beats), vecs[i].tdly, 1'b1, st);
                check($sformatf("vec%0d pkt%0d stalls", i, p), st, vecs[i].exp_stall[p]);
            end
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            check($sformatf("vec%0d pkt_count", i), pkt_count, vecs[i].npkts);
            check($sformatf("vec%0d passthrough", i), pt_bad, 0);
        end

        // Asynchronous reset in the middle of a 10-cycle gap, then ipd_en dropped during a gap.
        ipd_en        = 1'b1;
        delay_mode    = 2'd0;
        gap_mode      = 1'b0;
        delay_reg_val = 32'd10;
        burst_len     = 8'd1;
        pulse_sw_rst();
        send_pkt(1, '0, 1'b1, st);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check("gap entered", gap_active, 1);
        repeat (3) tick();
        axi_areset = 1'b1;
        #1;
        check("areset gap_active", gap_active, 0);
        check("areset s_tready", s_axis_tready, 1);
        check("areset pkt_count", pkt_count, 0);
        tick();
        axi_areset = 1'b0;
        send_pkt(4, '0, 1'b1, st);
        check("post-areset stall", st, 0);
        send_pkt(4, '0, 1'b1, st);
        check("post-areset gap", st, 10);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        ipd_en = 1'b0;
        tick();
        check("ipd_en drop in gap", gap_active, 0);

        // ipd_en raised mid-packet: gating starts from the next full packet.
        delay_reg_val = 32'd5;
        pulse_sw_rst();
        send_pkt(2, '0, 1'b0, st);
        check("en-off head stall", st, 0);
        ipd_en = 1'b1;
        send_pkt(2, '0, 1'b1, st);
        check("en-on tail stall", st, 0);
        send_pkt(4, '0, 1'b1, st);
        check("first gated pkt stall", st, 0);
        send_pkt(4, '0, 1'b1, st);
        check("first gated gap", st, 5);

        // sw_rst mid-packet: the rest of that packet must not be taken as a new packet.
        delay_reg_val = 32'd6;
        pulse_sw_rst();
        send_pkt(2, '0, 1'b0, st);
        pulse_sw_rst();
        check("sw_rst gap_active", gap_active, 0);
        send_pkt(2, '0, 1'b1, st);
        check("cut pkt tail stall", st, 0);
        send_pkt(4, '0, 1'b1, st);
        check("after cut pkt stall", st, 0);
        send_pkt(4, '0, 1'b1, st);
        check("after cut pkt gap", st, 6);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check("sw_rst pkt_count", pkt_count, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inter_packet_delay_mc.md
INTER_PACKET_DELAY_MC -- requirements
Module: inter_packet_delay_mc

Interface
REQ-001 SHALL have parameter C_AXIS_DATA_WIDTH, default 256: tdata width of both streams.
REQ-002 SHALL have parameter C_AXIS_TUSER_WIDTH, default 128: tuser width of both streams.
REQ-003 SHALL have parameter C_DELAY_WIDTH, default 32: width of the delay value and the gap counter.
REQ-004 SHALL have parameter C_TUSER_DELAY_LSB, default 32: LSB of the per-packet delay field in tuser, which is C_DELAY_WIDTH bits wide.
REQ-005 SHALL have ports axi_aclk (in, 1, sole clock) and axi_areset (in, 1, asynchronous active-high reset).
REQ-006 SHALL have slave stream ports s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid and s_axis_tlast (all in) and s_axis_tready (out), widths per REQ-001/002.
REQ-007 SHALL have master stream ports m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tvalid and m_axis_tlast (all out) and m_axis_tready (in).
REQ-008 SHALL have control inputs sw_rst (1), ipd_en (1), delay_mode (2; 0=register, 1=tuser, 2/3=unsigned max of both), gap_mode (1; 0=end-to-start, 1=start-to-start), delay_reg_val (C_DELAY_WIDTH) and burst_len (8).
REQ-009 SHALL have status outputs pkt_count (32, packets forwarded) and gap_active (1, high while the gate is closed).

Function
REQ-010 SHALL pass tdata, tstrb, tuser and tlast combinationally with zero latency and no modification.
REQ-011 SHALL drive m_axis_tvalid = s_axis_tvalid AND open, and s_axis_tready = m_axis_tready AND open, where open = (state != WAIT).
REQ-012 SHALL use states IDLE (no packet in flight), PASS (inside a packet) and WAIT (gap being enforced).
REQ-013 SHALL treat a beat as transferred when m_axis_tvalid and m_axis_tready are both high.
REQ-014 SHALL, on the first beat of a packet, select the packet delay per delay_mode from delay_reg_val and/or the tuser field, and latch it.
REQ-015 SHALL enter PASS from IDLE on a first beat with tlast low; a single-beat packet SHALL go straight to end-of-packet handling.
REQ-016 In gap_mode 1, SHALL load the counter with the latched delay on the first beat and decrement it by 1 per cycle while nonzero, including during PASS.
REQ-017 In gap_mode 0, SHALL load the counter with the latched delay on the tlast beat.
REQ-018 SHALL increment burst_cnt on each tlast beat; if burst_cnt reaches burst_len (0 treated as 1), it SHALL clear burst_cnt and go to WAIT if counter > 0, else to IDLE.
REQ-019 If burst_cnt has not reached burst_len on a tlast beat, SHALL go to IDLE with no gap.
REQ-020 In WAIT, SHALL decrement the counter each cycle and go to IDLE in the cycle it reaches 0; a delay of N SHALL therefore close the gate for exactly N cycles.
REQ-021 SHALL never underflow the counter: it saturates at 0.
REQ-022 SHALL never wrap pkt_count: it saturates at 2^32-1.
REQ-023 SHALL, while ipd_en is low, hold open=1 and keep the counter and burst_cnt at 0; pkt_count SHALL still count.
REQ-024 SHALL, if ipd_en is deasserted during WAIT, go to IDLE in the next cycle.
REQ-025 SHALL act on delay_mode, gap_mode and burst_len changes only at packet boundaries; the latched delay governs the current packet.
REQ-026 SHALL, when a tlast beat and counter reaching 0 occur in the same cycle in gap_mode 1, take REQ-018 with counter treated as 0.

Reset
REQ-027 SHALL, on axi_areset, asynchronously set state=IDLE and clear counter, burst_cnt, latched delay and pkt_count to 0, with gap_active=0 and m_axis_tvalid following s_axis_tvalid.
REQ-028 SHALL give sw_rst the same effect as REQ-027, applied synchronously at the next clock edge.
REQ-029 SHALL, when reset occurs mid-packet, make the remaining beats pass ungated; a new packet is recognised only after the next tlast.

Structure
REQ-030 SHALL place the state encoding and the delay_mode/gap_mode constants in the shared package ipd_pkg.
REQ-031 SHALL implement the loadable, saturating down-counter as sub-module ipd_gap_counter (ports: load, load_val, dec, count, zero).

Verification
REQ-032 Mode 0, gap 0, delay_reg_val=10, burst_len=1, two back-to-back 4-beat packets -> exactly 10 cycles with s_axis_tready=0 between the tlast of packet 1 and its first beat.
REQ-033 Mode 1, tuser delay field=5, reg=20 -> 5-cycle gap; mode 2 with the same values -> 20-cycle gap.
REQ-034 Gap 1, delay=8, 6-beat packet with tready always high -> 2-cycle gap after tlast; delay=3 -> 0-cycle gap.
REQ-035 burst_len=3, delay=4, five single-beat packets -> a gap only after packet 3; pkt_count=5.
REQ-036 axi_areset pulsed during WAIT with counter=7 -> gap_active=0 immediately, and the next packet passes with no stall.
REQ-037 ipd_en=0, delay=100 -> no stalls; toggling ipd_en to 1 mid-stream -> gating starts from the next packet boundary.
